mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Two-requester controller for the single-port main memory model. Port 0 is the
//   instruction-fetch side (read-only); port 1 is the data side (read/write).
//   Arbitrates round-robin, holds the memory address/data stable for a fixed
//   access latency, then returns one response pulse to the winning requester.
//   Sits between the L1 cache refill logic and the memory block.
// PARAMETERS
//   ACCESS_LAT  2  cycles the address is held on the memory port per access (>=1)
//   Address width is `MEM_ADDR_SIZE; data width is `MEM_BANDWIDTH*8 (global macros).
// PORTS
//   clk             in   1    clock; all state updates on posedge
//   rst             in   1    synchronous, active-high reset
//   req0_valid      in   1    port 0 read request
//   req0_addr       in   AW   port 0 address
//   req0_ready      out  1    port 0 request accepted this cycle (valid&&ready)
//   resp0_valid     out  1    one-cycle pulse: port 0 read data valid
//   resp0_data      out  DW   port 0 read data
//   req1_valid      in   1    port 1 request
//   req1_write      in   1    1 = write, 0 = read
//   req1_addr       in   AW   port 1 address
//   req1_wdata      in   DW   port 1 write data
//   req1_ready      out  1    port 1 request accepted this cycle
//   resp1_valid     out  1    one-cycle pulse: port 1 read data / write ack
//   resp1_data      out  DW   port 1 read data (0 for write acks)
//   mem_addr        out  AW   to memory: address
//   mem_write_data  out  DW   to memory: write data
//   mem_write_valid out  1    to memory: write strobe
//   mem_data        in   DW   from memory: read data (combinational on mem_addr)
//   mem_valid       in   1    from memory: data/port usable this cycle
// BEHAVIOUR
//   - States: IDLE, ACCESS, RESP. Reset -> IDLE.
//   - Reset values: all ready/resp_valid 0, resp data 0, mem_addr 0,
//     mem_write_data 0, mem_write_valid 0, last_grant=1 (port 0 wins first tie).
//   - IDLE: reqN_ready is combinational, asserted only for the winner:
//     single valid -> that port; both valid -> port != last_grant. ready is 0 in
//     ACCESS/RESP and whenever rst=1. On acceptance latch addr, wdata, write
//     (port 0 write forced 0), owner id; last_grant<=owner; cnt<=ACCESS_LAT-1;
//     -> ACCESS.
//   - ACCESS: mem_addr/mem_write_data = latched values (registered, stable all
//     cycles). cnt decrements only when mem_valid=1. When cnt==0 and mem_valid=1:
//     capture mem_data (read) into owner's resp_data, mem_write_valid=1 this cycle
//     only if latched write, -> RESP. mem_valid=0 at cnt==0 stalls in place with
//     no write strobe.
//   - RESP: resp<owner>_valid=1 exactly one cycle; other port's resp_valid 0;
//     -> IDLE. No request accepted in RESP.
//   - Latency: accept at cycle T -> resp_valid at T+ACCESS_LAT+1 (mem_valid held 1).
//     Peak throughput one access per ACCESS_LAT+2 cycles.
//   - mem_addr keeps its last value in IDLE/RESP; mem_write_valid 0 outside the
//     final ACCESS cycle. resp_data holds until next response to that port.
//   - Reset mid-operation: access aborted, no response, no write strobe
//     (mem_write_valid gated by !rst), last_grant back to 1.
//   - Counter width $clog2(ACCESS_LAT+1); no wrap (loads, counts down to 0).
// CONFIGURATION
//   MEM_ARB_STATS_EN defined: adds outputs grant_cnt0, grant_cnt1 (32 bit each),
//     reset to 0, +1 on each acceptance for that port, wrap 0xFFFFFFFF->0.
//   Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//   1 Reset 3 cycles, idle inputs -> all outputs 0, no ready while rst=1.
//   2 req0 read addr 0x10 (mem[0x10]=0xA5), ACCESS_LAT=2 -> req0_ready T,
//     resp0_valid exactly at T+3, resp0_data=0xA5, resp1_valid stays 0.
//   3 req1 write 0x20 data 0x55, then req1 read 0x20 -> single mem_write_valid
//     pulse with addr 0x20; write ack resp1_data=0; read returns 0x55.
//   4 req0 and req1 valid continuously for 6 accesses -> grants 0,1,0,1,0,1;
//     with MEM_ARB_STATS_EN grant_cnt0=grant_cnt1=3.
//   5 mem_valid low 4 cycles during ACCESS -> response delayed exactly 4 cycles,
//     mem_addr unchanged, no write strobe while stalled.
//   6 rst asserted during ACCESS of a write -> no mem_write_valid, no resp, memory
//     location unchanged; next tie after reset granted to port 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin two-port front end for the single-port memory model; holds each access for ACCESS_LAT beats.
// Define MEM_ARB_STATS_EN to add the per-port 32-bit grant counters grant_cnt0/grant_cnt1.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 16
`endif
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 4
`endif

module mem_arbiter #(
    parameter int ACCESS_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0_valid,
    input  logic [`MEM_ADDR_SIZE-1:0]     req0_addr,
    output logic                          req0_ready,
    output logic                          resp0_valid,
    output logic [`MEM_BANDWIDTH*8-1:0]   resp0_data,
    input  logic                          req1_valid,
    input  logic                          req1_write,
    input  logic [`MEM_ADDR_SIZE-1:0]     req1_addr,
    input  logic [`MEM_BANDWIDTH*8-1:0]   req1_wdata,
    output logic                          req1_ready,
    output logic                          resp1_valid,
    output logic [`MEM_BANDWIDTH*8-1:0]   resp1_data,
    output logic [`MEM_ADDR_SIZE-1:0]     mem_addr,
    output logic [`MEM_BANDWIDTH*8-1:0]   mem_write_data,
    output logic                          mem_write_valid,
    input  logic [`MEM_BANDWIDTH*8-1:0]   mem_data,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]                   grant_cnt0,
    output logic [31:0]                   grant_cnt1,
`endif
    input  logic                          mem_valid
);

    localparam int AW = `MEM_ADDR_SIZE;
    localparam int DW = `MEM_BANDWIDTH * 8;
    localparam int CW = $clog2(ACCESS_LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            owner_q, owner_d;
    logic            write_q, write_d;
    logic            last_grant_q, last_grant_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            resp0_valid_q, resp0_valid_d;
    logic            resp1_valid_q, resp1_valid_d;
    logic [DW-1:0]   resp0_data_q, resp0_data_d;
    logic [DW-1:0]   resp1_data_q, resp1_data_d;
    logic            grant0;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]     grant_cnt0_q, grant_cnt0_d;
    logic [31:0]     grant_cnt1_q, grant_cnt1_d;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d         = state_q;
        cnt_d           = cnt_q;
        owner_d         = owner_q;
        write_d         = write_q;
        last_grant_d    = last_grant_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        resp0_valid_d   = 1'b0;
        resp1_valid_d   = 1'b0;
        resp0_data_d    = resp0_data_q;
        resp1_data_d    = resp1_data_q;
        req0_ready      = 1'b0;
        req1_ready      = 1'b0;
        mem_write_valid = 1'b0;
`ifdef MEM_ARB_STATS_EN
        grant_cnt0_d    = grant_cnt0_q;
        grant_cnt1_d    = grant_cnt1_q;
`endif
        // last_grant_q == 1 means port 1 went last, so port 0 wins a tie.
        grant0 = req0_valid && (!req1_valid || last_grant_q);

        unique case (state_q)
            IDLE: begin
                if (!rst) begin
                    req0_ready = grant0;
                    req1_ready = req1_valid && !grant0;
                    if (req0_ready || req1_ready) begin
                        owner_d      = req1_ready;
                        last_grant_d = req1_ready;
                        write_d      = req1_ready && req1_write;
                        mem_addr_d   = req1_ready ? req1_addr : req0_addr;
                        mem_wdata_d  = req1_ready ? req1_wdata : '0;
                        cnt_d        = CNT_LOAD;
                        state_d      = ACCESS;
`ifdef MEM_ARB_STATS_EN
                        if (req0_ready) grant_cnt0_d = grant_cnt0_q + 32'd1;
                        if (req1_ready) grant_cnt1_d = grant_cnt1_q + 32'd1;
`endif
                    end
                end
            end
            ACCESS: begin
                if (mem_valid) begin
                    if (cnt_q == '0) begin
                        mem_write_valid = write_q && !rst;
                        if (owner_q) begin
                            resp1_data_d  = write_q ? '0 : mem_data;
                            resp1_valid_d = 1'b1;
                        end else begin
                            resp0_data_d  = mem_data;
                            resp0_valid_d = 1'b1;
                        end
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            owner_q       <= 1'b0;
            write_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_data_q  <= '0;
            resp1_data_q  <= '0;
`ifdef MEM_ARB_STATS_EN
            grant_cnt0_q  <= '0;
            grant_cnt1_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            write_q       <= write_d;
            last_grant_q  <= last_grant_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_data_q  <= resp0_data_d;
            resp1_data_q  <= resp1_data_d;
`ifdef MEM_ARB_STATS_EN
            grant_cnt0_q  <= grant_cnt0_d;
            grant_cnt1_q  <= grant_cnt1_d;
`endif
        end
    end

    assign resp0_valid    = resp0_valid_q;
    assign resp1_valid    = resp1_valid_q;
    assign resp0_data     = resp0_data_q;
    assign resp1_data     = resp1_data_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
`ifdef MEM_ARB_STATS_EN
    assign grant_cnt0     = grant_cnt0_q;
    assign grant_cnt1     = grant_cnt1_q;
`endif

endmodule
